// File: rtl/ps2_host_phy_if.sv
// Byte-level handshake between the PS/2 PHY and its client: received bytes and
// send requests, all single-cycle strobes qualified by the system clock.
interface ps2_host_phy_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        input  rx_data, rx_valid, rx_err, tx_busy, tx_done, tx_err,
        output tx_data, tx_start
    );

    modport slave (
        output rx_data, rx_valid, rx_err, tx_busy, tx_done, tx_err,
        input  tx_data, tx_start
    );
endinterface

// File: rtl/ps2_host_phy.sv
// PS/2 host line PHY: sync + de-glitch of clock/data, device->host framing, host->device send with ACK.
// Latency: pin edge to internal strobe is 2+FILTER_LEN enables; results pulse one clk after the frame's last edge.
// Backpressure: none; tx_start is accepted only while idle and dropped (not queued) while tx_busy is high.
module ps2_host_phy #(
    parameter int FILTER_LEN  = 8,
    parameter int INHIBIT_CYC = 800,
    parameter int TIMEOUT_CYC = 14000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk7_en,
    input  logic           ps2clk_i,
    input  logic           ps2dat_i,
    output logic           ps2clk_o,
    output logic           ps2dat_o,
    ps2_host_phy_if.slave  bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(((TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC) + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_INHIBIT, S_REQ, S_TX, S_ACK, S_WAIT_REL
    } state_t;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d;
    logic [FW-1:0] dat_cnt_q, dat_cnt_d;
    logic          fclk_q, fclk_d;
    logic          fdat_q, fdat_d;
    logic          fclk_fall;

    // A filtered level flips only after FILTER_LEN consecutive enabled samples disagree with it.
    always_comb begin
        clk_sync_d = clk_sync_q;
        dat_sync_d = dat_sync_q;
        clk_cnt_d  = clk_cnt_q;
        dat_cnt_d  = dat_cnt_q;
        fclk_d     = fclk_q;
        fdat_d     = fdat_q;
        fclk_fall  = 1'b0;
        if (clk7_en) begin
            clk_sync_d = {clk_sync_q[0], ps2clk_i};
            dat_sync_d = {dat_sync_q[0], ps2dat_i};

            if (clk_sync_q[1] == fclk_q) begin
                clk_cnt_d = '0;
            end else if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_cnt_d = '0;
                fclk_d    = clk_sync_q[1];
                fclk_fall = fclk_q;
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end

            if (dat_sync_q[1] == fdat_q) begin
                dat_cnt_d = '0;
            end else if (dat_cnt_q == FW'(FILTER_LEN - 1)) begin
                dat_cnt_d = '0;
                fdat_d    = dat_sync_q[1];
            end else begin
                dat_cnt_d = dat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
            fclk_q     <= 1'b1;
            fdat_q     <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_cnt_q  <= clk_cnt_d;
            dat_cnt_q  <= dat_cnt_d;
            fclk_q     <= fclk_d;
            fdat_q     <= fdat_d;
        end
    end

    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [TW-1:0] timer_q;
    logic [8:0]    rx_sh_q;
    logic [9:0]    tx_sh_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, rx_err_q, tx_done_q, tx_err_q;
    logic          ps2clk_o_q, ps2dat_o_q;
    logic          watched;

    assign watched = (state_q == S_RX) || (state_q == S_REQ) || (state_q == S_TX) ||
                     (state_q == S_ACK) || (state_q == S_WAIT_REL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            ps2clk_o_q <= 1'b1;
            ps2dat_o_q <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_err_q   <= 1'b0;
            if (clk7_en) begin
                if (watched && !fclk_fall && timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Device stopped clocking: let go of the bus and report against the active direction.
                    ps2clk_o_q <= 1'b1;
                    ps2dat_o_q <= 1'b1;
                    state_q    <= S_IDLE;
                    if (state_q == S_RX) rx_err_q <= 1'b1;
                    else                 tx_err_q <= 1'b1;
                end else begin
                    if (watched) timer_q <= fclk_fall ? '0 : timer_q + 1'b1;
                    unique case (state_q)
                        S_IDLE: begin
                            if (bus.tx_start) begin
                                tx_sh_q    <= {1'b1, ~^bus.tx_data, bus.tx_data};
                                ps2clk_o_q <= 1'b0;
                                timer_q    <= '0;
                                state_q    <= S_INHIBIT;
                            end else if (fclk_fall && !fdat_q) begin
                                bit_cnt_q <= '0;
                                timer_q   <= '0;
                                state_q   <= S_RX;
                            end
                        end
                        S_RX: begin
                            if (fclk_fall) begin
                                if (bit_cnt_q == 4'd9) begin
                                    if ((^rx_sh_q) && fdat_q) begin
                                        rx_data_q  <= rx_sh_q[7:0];
                                        rx_valid_q <= 1'b1;
                                    end else begin
                                        rx_err_q <= 1'b1;
                                    end
                                    state_q <= S_IDLE;
                                end else begin
                                    rx_sh_q   <= {fdat_q, rx_sh_q[8:1]};
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                end
                            end
                        end
                        S_INHIBIT: begin
                            if (timer_q == TW'(INHIBIT_CYC - 1)) begin
                                ps2dat_o_q <= 1'b0;
                                ps2clk_o_q <= 1'b1;
                                timer_q    <= '0;
                                bit_cnt_q  <= '0;
                                state_q    <= S_REQ;
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                        S_REQ, S_TX: begin
                            if (fclk_fall) begin
                                ps2dat_o_q <= tx_sh_q[0];
                                tx_sh_q    <= {1'b1, tx_sh_q[9:1]};
                                bit_cnt_q  <= bit_cnt_q + 1'b1;
                                state_q    <= (bit_cnt_q == 4'd9) ? S_ACK : S_TX;
                            end
                        end
                        S_ACK: begin
                            if (fclk_fall) begin
                                if (!fdat_q) begin
                                    state_q <= S_WAIT_REL;
                                end else begin
                                    tx_err_q <= 1'b1;
                                    state_q  <= S_IDLE;
                                end
                            end
                        end
                        S_WAIT_REL: begin
                            if (fclk_q && fdat_q) begin
                                tx_done_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign ps2clk_o     = ps2clk_o_q;
    assign ps2dat_o     = ps2dat_o_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.tx_busy  = (state_q != S_IDLE);
    assign bus.tx_done  = tx_done_q;
    assign bus.tx_err   = tx_err_q;

endmodule
